cntry_sensor_req: RTL and testbench
===================================

// Module: cntry_sensor_req
// PURPOSE
//  Country-road vehicle-detector front end that generates the car-request input x for the
//  highway/country traffic controller. Syncs and debounces the raw loop detector and latches
//  a request until the country road is served. Watches the controller's hwy/cntry lights to
//  cap country green time and enforce a highway hold-off.
// PARAMETERS
//  DEB_CYC      4   consecutive cycles the synced raw input must differ from pres to change it (>=1)
//  MAX_GREEN    8   max cycles x may stay high while cntry is green (extension cap)
//  HOLDOFF_CYC  5   cycles x is forced low after cntry leaves green
//  CNT_W        8   width of car_cnt
// PORTS
//  clk       in   1      system clock, all flops on posedge
//  clear     in   1      reset, asynchronous, active-low (0 = reset)
//  loop_raw  in   1      raw loop detector, asynchronous to clk, may bounce
//  hwy       in   2      highway light from controller (red=0, yellow=1, green=2)
//  cntry     in   2      country light from controller (same encoding)
//  x         out  1      car request to controller
//  pres      out  1      debounced vehicle presence (registered)
//  car_cnt   out  CNT_W  count of pres rising edges, wraps to 0
//  err       out  1      sticky illegal-light flag
// BEHAVIOUR
//  Reset (clear=0): sync flops=0, pres=0, deb_cnt=0, state=IDLE, x=0, car_cnt=0, err=0,
//   green_cnt=0, hold_cnt=0. Applies immediately; a mid-operation reset drops x the same cycle.
//  Sync: two flops, loop_raw->s1->s2. Only s2 is used downstream.
//  Debounce: if s2==pres, deb_cnt<=0. Otherwise deb_cnt++; when deb_cnt==DEB_CYC-1,
//   pres<=s2 and deb_cnt<=0. A clean raw step reaches pres in 2+DEB_CYC edges.
//  car_cnt increments on the edge after pres goes 0->1; it wraps from 2^CNT_W-1 to 0.
//  FSM (registered state; x is a decode of registered signals, so it is glitch-free):
//   IDLE   : x=0. If pres and cntry!=green, go to REQ.
//   REQ    : x=1. The request is latched: pres falling does NOT clear it.
//            If cntry==green, go to SERVE and set green_cnt<=0.
//   SERVE  : x = pres & (green_cnt<MAX_GREEN). green_cnt++ each cycle, saturating.
//            If cntry!=green, go to HOLDOFF and set hold_cnt<=0.
//   HOLDOFF: x=0 regardless of pres. hold_cnt++.
//            When hold_cnt==HOLDOFF_CYC-1, go to IDLE.
//  Simultaneous events:
//   - pres rises in the same cycle cntry turns green while in IDLE: stay in IDLE. REQ is entered
//     only once cntry!=green.
//   - cntry leaves green on the cycle the timeout is reached: go to HOLDOFF, x=0.
//   - If pres is still 1 when leaving HOLDOFF: IDLE lasts 1 cycle, then REQ.
//  err is set on the edge after any illegal light condition: hwy==3, cntry==3, or hwy!=red while
//   cntry!=red. It is cleared only by reset. err does not alter the FSM.
//  Latency: pres 0->1 in IDLE -> x=1 after exactly 1 edge.
// STRUCTURE
//  Package traffic_pkg holds:
//   - light constants red/yellow/green (2'd0/1/2)
//   - request-FSM state constants IDLE/REQ/SERVE/HOLDOFF (2-bit)
//  Sub-module sensor_debounce (clk, clear, raw, pres) contains the sync flops and deb_cnt.
//  The top level holds the FSM, green_cnt, hold_cnt, car_cnt and err.
// TESTING
//  1 Reset during SERVE with x=1: clear=0 -> x=0, pres=0, car_cnt=0, err=0 with no clock edge.
//  2 Bounce rejection (DEB_CYC=4): loop_raw toggles every 2 cycles -> pres stays 0.
//    Then hold loop_raw=1 -> pres=1 on edge 6, x=1 on edge 7, car_cnt=1.
//  3 Latched request: in REQ, drop loop_raw until pres=0 -> x stays 1.
//    Drive cntry=green -> SERVE, x=0 because pres=0.
//  4 Green cap: pres=1, cntry=green, hwy=red -> x=1 for 8 SERVE cycles, then x=0
//    while cntry stays green.
//  5 Hold-off: cntry green->yellow with pres=1 -> x=0 for 5 cycles, 1 cycle in IDLE,
//    then x=1 (REQ).
//  6 Illegal lights: hwy=green and cntry=green -> err=1 on the next edge.
//    Restore legal lights -> err stays 1 until reset.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encodings and request-FSM states
// Purpose: constants shared by the country-road sensor front end and its bench.
// Ports: none (package).
package traffic_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVE   = 2'd2,
    HOLDOFF = 2'd3
  } req_state_e;

endpackage

// File: rtl/cntry_sensor_req_if.sv
// rtl/cntry_sensor_req_if.sv - light/request link between controller and country sensor
// Purpose: bundles the controller's light outputs and the car-request returned to it.
// Ports (members):
//   hwy   [1:0]  highway light, driven by the controller
//   cntry [1:0]  country light, driven by the controller
//   x            car request, driven by the sensor front end
interface cntry_sensor_req_if;

  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       x;

  // controller side
  modport master (output hwy, output cntry, input x);
  // sensor side
  modport slave (input hwy, input cntry, output x);

endinterface

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchroniser and counter debouncer for the loop detector
// Purpose: brings loop_raw into the clk domain and only updates pres after the synced
//   input has disagreed with it for DEB_CYC consecutive cycles.
// Ports:
//   clk    in   system clock
//   clear  in   asynchronous active-low reset
//   raw    in   raw loop detector, asynchronous, may bounce
//   pres   out  debounced presence (registered)
module sensor_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic raw,
  output logic pres
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      pres    <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // any agreement restarts the run, so a bounce shorter than DEB_CYC never lands
      if (s2 == pres) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        pres    <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/cntry_sensor_req.sv
// rtl/cntry_sensor_req.sv - country-road car-request generator with green cap and hold-off
// Purpose: debounces the country loop detector, latches a car request until the country
//   road is served, caps how long the request can extend a country green, and holds the
//   request off for a while after the country green ends. Flags illegal light combinations.
// Ports:
//   clk       in   system clock, posedge
//   clear     in   asynchronous active-low reset
//   loop_raw  in   raw loop detector, asynchronous, may bounce
//   ctrl      if   slave side of the light/request link (hwy, cntry in; x out)
//   pres      out  debounced vehicle presence
//   car_cnt   out  count of pres rising edges, wrapping
//   err       out  sticky illegal-light flag
module cntry_sensor_req
  import traffic_pkg::*;
#(
  parameter int DEB_CYC     = 4,
  parameter int MAX_GREEN   = 8,
  parameter int HOLDOFF_CYC = 5,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               loop_raw,
  cntry_sensor_req_if.slave  ctrl,
  output logic               pres,
  output logic [CNT_W-1:0]   car_cnt,
  output logic               err
);

  localparam int GW = $clog2(MAX_GREEN + 1);
  localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [GW-1:0] GREEN_MAX = GW'(MAX_GREEN);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYC - 1);

  req_state_e    state_q;
  req_state_e    state_d;
  logic [GW-1:0] green_cnt;
  logic [GW-1:0] green_d;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_d;
  logic          x_d;
  logic          pres_d;
  logic          cntry_green;
  logic          illegal;

  sensor_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk   (clk),
    .clear (clear),
    .raw   (loop_raw),
    .pres  (pres)
  );

  assign cntry_green = (ctrl.cntry == GREEN);
  assign illegal     = (ctrl.hwy == 2'd3) || (ctrl.cntry == 2'd3) ||
                       ((ctrl.hwy != RED) && (ctrl.cntry != RED));

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      green_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      green_cnt <= green_d;
      hold_cnt  <= hold_d;
    end
  end

  // x depends only on registered values, so it cannot glitch on light changes
  always_comb begin
    state_d = state_q;
    green_d = green_cnt;
    hold_d  = hold_cnt;
    x_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // a car arriving while the country road is already green waits here
        if (pres && !cntry_green) state_d = REQ;
      end
      REQ: begin
        // latched: pres falling does not withdraw the request
        x_d = 1'b1;
        if (cntry_green) begin
          state_d = SERVE;
          green_d = '0;
        end
      end
      SERVE: begin
        x_d = pres && (green_cnt < GREEN_MAX);
        if (green_cnt != GREEN_MAX) green_d = green_cnt + GW'(1);
        if (!cntry_green) begin
          state_d = HOLDOFF;
          hold_d  = '0;
        end
      end
      HOLDOFF: begin
        hold_d = hold_cnt + HW'(1);
        if (hold_cnt == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ctrl.x = x_d;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      pres_d  <= 1'b0;
      car_cnt <= '0;
      err     <= 1'b0;
    end else begin
      pres_d <= pres;
      if (pres && !pres_d) car_cnt <= car_cnt + CNT_W'(1);
      if (illegal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cntry_sensor_req.sv
// tb/tb_cntry_sensor_req.sv - directed self-checking bench for cntry_sensor_req
module tb_cntry_sensor_req;
  import traffic_pkg::*;

  logic       clk;
  logic       clear;
  logic       loop_raw;
  logic       pres;
  logic [7:0] car_cnt;
  logic       err;
  int         pass_cnt;
  int         total_cnt;

  cntry_sensor_req_if bus ();

  cntry_sensor_req #(
    .DEB_CYC     (4),
    .MAX_GREEN   (8),
    .HOLDOFF_CYC (5),
    .CNT_W       (8)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .loop_raw (loop_raw),
    .ctrl     (bus),
    .pres     (pres),
    .car_cnt  (car_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    clear     = 1'b0;
    loop_raw  = 1'b0;
    bus.hwy   = GREEN;
    bus.cntry = RED;
    #3;
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_pres", 32'(pres), 32'd0);
    chk("rst_car_cnt", 32'(car_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step(1);
    clear = 1'b1;
    step(2);

    // bounce rejection: toggle every 2 cycles
    for (int i = 0; i < 4; i++) begin
      loop_raw = 1'b1;
      step(2);
      chk("bounce_pres_hi", 32'(pres), 32'd0);
      loop_raw = 1'b0;
      step(2);
      chk("bounce_pres_lo", 32'(pres), 32'd0);
    end
    step(4);
    chk("bounce_quiet", 32'(pres), 32'd0);

    // clean step: pres on edge 6, x and car_cnt on edge 7
    loop_raw = 1'b1;
    step(5);
    chk("deb_edge5_pres", 32'(pres), 32'd0);
    step(1);
    chk("deb_edge6_pres", 32'(pres), 32'd1);
    chk("deb_edge6_x", 32'(bus.x), 32'd0);
    chk("deb_edge6_cnt", 32'(car_cnt), 32'd0);
    step(1);
    chk("req_edge7_x", 32'(bus.x), 32'd1);
    chk("req_edge7_cnt", 32'(car_cnt), 32'd1);
    chk("legal_err", 32'(err), 32'd0);

    // latched request survives pres falling
    loop_raw = 1'b0;
    step(6);
    chk("latch_pres", 32'(pres), 32'd0);
    chk("latch_x", 32'(bus.x), 32'd1);
    bus.hwy   = RED;
    bus.cntry = GREEN;
    step(1);
    chk("serve_nopres_x", 32'(bus.x), 32'd0);

    // leave serve, let hold-off expire with a car arriving, get back to REQ
    loop_raw  = 1'b1;
    bus.cntry = RED;
    step(10);
    chk("rereq_x", 32'(bus.x), 32'd1);
    chk("rereq_cnt", 32'(car_cnt), 32'd2);

    // green cap: 8 cycles of x=1 then x=0 while still green
    bus.cntry = GREEN;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("cap_x_%0d", i), 32'(bus.x), 32'd1);
    end
    step(1);
    chk("cap_expired_x", 32'(bus.x), 32'd0);
    step(2);
    chk("cap_still_green_x", 32'(bus.x), 32'd0);

    // hold-off: 5 cycles forced low, 1 cycle IDLE, then REQ
    bus.cntry = YELLOW;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("holdoff_x_%0d", i), 32'(bus.x), 32'd0);
    end
    step(1);
    chk("holdoff_idle_x", 32'(bus.x), 32'd0);
    step(1);
    chk("holdoff_req_x", 32'(bus.x), 32'd1);
    chk("holdoff_err", 32'(err), 32'd0);

    // illegal lights then legal again: err is sticky
    bus.hwy   = GREEN;
    bus.cntry = GREEN;
    step(1);
    chk("illegal_err", 32'(err), 32'd1);
    bus.hwy = RED;
    step(3);
    chk("sticky_err", 32'(err), 32'd1);
    chk("serve_x_before_rst", 32'(bus.x), 32'd1);

    // asynchronous reset during SERVE with x=1, observed with no clock edge
    #2;
    clear = 1'b0;
    #1;
    chk("async_rst_x", 32'(bus.x), 32'd0);
    chk("async_rst_pres", 32'(pres), 32'd0);
    chk("async_rst_cnt", 32'(car_cnt), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);

    // pres rises while cntry already green: stay in IDLE until cntry leaves green
    step(1);
    clear = 1'b1;
    step(8);
    chk("idle_green_pres", 32'(pres), 32'd1);
    chk("idle_green_x", 32'(bus.x), 32'd0);
    chk("idle_green_cnt", 32'(car_cnt), 32'd1);
    bus.cntry = RED;
    step(1);
    chk("idle_red_req_x", 32'(bus.x), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
